// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the 2D FIR datapath.
//   clog2_min1      : counter width helper that never returns a zero width
//   DEFAULT_LINE_W  : pixels per line used by the filter top
//   DEFAULT_LINES   : lines per frame used by the filter top
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int DEFAULT_LINE_W = 640;
  localparam int DEFAULT_LINES  = 480;

  // A counter over a range of one value still needs a single bit of storage.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// ---------------------------------------------------------------------------
// axis_skid_reg
// Two-entry output stage: a main register driving the stream outputs and a
// skid register that catches one extra word while the consumer stalls.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid       : a new word is written this edge (producer guarantees it
//                    never asserts while skid_valid is set)
//   in_payload     : word to store
//   out_ready      : downstream accept
//   out_valid      : main entry holds a word
//   out_payload    : main entry contents
//   skid_valid     : skid entry holds a word
// ---------------------------------------------------------------------------
module axis_skid_reg #(
  parameter int PW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [PW-1:0] in_payload,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [PW-1:0] out_payload,
  output logic          skid_valid
);

  logic [PW-1:0] skid_payload;
  logic          hs;

  assign hs = out_valid & out_ready;

  // Incoming words go straight to main when main is free or being emptied;
  // otherwise they park in skid. The skid word moves up on the next
  // handshake that has no fresh word competing for main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_payload  <= '0;
      skid_valid   <= 1'b0;
      skid_payload <= '0;
    end else if (in_valid && (!out_valid || hs)) begin
      out_valid   <= 1'b1;
      out_payload <= in_payload;
    end else if (in_valid) begin
      skid_valid   <= 1'b1;
      skid_payload <= in_payload;
    end else if (hs && skid_valid) begin
      out_payload <= skid_payload;
      skid_valid  <= 1'b0;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
// Drains a show-ahead FIFO into a stream master, tagging each beat with
// start-of-frame (m_tuser) and end-of-line (m_tlast).
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   empty, q           : FIFO empty flag and head data
//   rd                 : FIFO pop strobe
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tuser : stream master
//   frame_done         : one-cycle pulse after the last beat of a frame
// ---------------------------------------------------------------------------
module fifo_stream_reader
  import fir_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LINE_W = DEFAULT_LINE_W,
  parameter int LINES  = DEFAULT_LINES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             empty,
  input  logic [WIDTH-1:0] q,
  output logic             rd,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic             frame_done
);

  localparam int X_W = clog2_min1(LINE_W);
  localparam int Y_W = clog2_min1(LINES);
  localparam int PW  = WIDTH + 3;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           skid_valid;
  logic           tag_last;
  logic           tag_sof;
  logic           tag_eof;
  logic [PW-1:0]  in_payload;
  logic [PW-1:0]  out_payload;
  logic           main_eof;

  // Pop only when the skid entry is free, so at most two words are ever in
  // flight and m_tready never reaches rd combinationally.
  assign rd = rst_n & ~empty & ~skid_valid;

  assign tag_last = (x == X_W'(LINE_W - 1));
  assign tag_sof  = (x == '0) && (y == '0);
  assign tag_eof  = tag_last && (y == Y_W'(LINES - 1));

  assign in_payload = {tag_eof, tag_sof, tag_last, q};

  // Position counters track the next word to be popped; compared against
  // the real line/frame sizes so non-power-of-two geometries wrap correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (rd) begin
      if (tag_last) begin
        x <= '0;
        y <= (y == Y_W'(LINES - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  axis_skid_reg #(.PW(PW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (rd),
    .in_payload  (in_payload),
    .out_ready   (m_tready),
    .out_valid   (m_tvalid),
    .out_payload (out_payload),
    .skid_valid  (skid_valid)
  );

  assign main_eof = out_payload[WIDTH+2];
  assign m_tuser  = out_payload[WIDTH+1];
  assign m_tlast  = out_payload[WIDTH];
  assign m_tdata  = out_payload[WIDTH-1:0];

  // Pulse once the final beat of a frame has actually been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_tvalid & m_tready & main_eof;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader
// Drives a queue-based show-ahead FIFO into fifo_stream_reader and compares
// every cycle against a stream-level reference: the set of words in flight,
// their frame position derived from the pop index, and the accept order.
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int WIDTH  = 8;
  localparam int LINE_W = 4;
  localparam int LINES  = 2;
  localparam int FRAME  = LINE_W * LINES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             empty;
  logic [WIDTH-1:0] q;
  logic             rd;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic             m_tuser;
  logic             frame_done;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             sof;
    logic             eof;
  } beat_t;

  logic [WIDTH-1:0] fifo_q[$];
  beat_t            exp_q[$];
  beat_t            acc_log[$];
  logic             hold_empty;
  logic             exp_fd;
  int               pop_index;
  int               rd_pulses;
  int               fd_pulses;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(WIDTH), .LINE_W(LINE_W), .LINES(LINES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .empty      (empty),
    .q          (q),
    .rd         (rd),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveFifo();
    empty = hold_empty || (fifo_q.size() == 0);
    q     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic applyStimulus(input logic ready, input logic bubble);
    logic  rd_now;
    logic  fd_next;
    beat_t b;
    int    xpos;
    int    ypos;
    m_tready   = ready;
    hold_empty = bubble;
    driveFifo();
    #1;
    checkOutput("rd", rd, (!empty && exp_q.size() < 2));
    checkOutput("m_tvalid", m_tvalid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      checkOutput("m_tdata", m_tdata, exp_q[0].data);
      checkOutput("m_tlast", m_tlast, exp_q[0].last);
      checkOutput("m_tuser", m_tuser, exp_q[0].sof);
    end
    checkOutput("frame_done", frame_done, exp_fd);
    if (frame_done) fd_pulses++;
    rd_now  = rd;
    fd_next = 1'b0;
    @(posedge clk);
    if (exp_q.size() > 0 && ready) begin
      fd_next = exp_q[0].eof;
      acc_log.push_back(exp_q.pop_front());
    end
    if (rd_now) begin
      rd_pulses++;
      xpos   = pop_index % LINE_W;
      ypos   = pop_index / LINE_W;
      b.data = fifo_q.pop_front();
      b.last = (xpos == LINE_W - 1);
      b.sof  = (pop_index == 0);
      b.eof  = (xpos == LINE_W - 1) && (ypos == LINES - 1);
      exp_q.push_back(b);
      pop_index = (pop_index + 1) % FRAME;
    end
    exp_fd = fd_next;
    @(negedge clk);
  endtask

  // Reset drops everything in flight; the FIFO itself keeps its contents.
  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_m_tvalid", m_tvalid, 0);
    checkOutput("rst_rd", rd, 0);
    checkOutput("rst_m_tdata", m_tdata, 0);
    checkOutput("rst_m_tlast", m_tlast, 0);
    checkOutput("rst_m_tuser", m_tuser, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    exp_q.delete();
    pop_index = 0;
    exp_fd    = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runUntilIdle(input int max_cycles, input bit random_mode);
    int  n;
    logic idle;
    n    = 0;
    idle = (fifo_q.size() == 0) && (exp_q.size() == 0) && !exp_fd;
    while (!idle && n < max_cycles) begin
      if (random_mode) applyStimulus(1'($urandom % 2), 1'($urandom % 3 == 0));
      else             applyStimulus(1'b1, 1'b0);
      n++;
      idle = (fifo_q.size() == 0) && (exp_q.size() == 0) && !exp_fd;
    end
    checkOutput("drain_done", idle, 1);
  endtask

  task automatic loadSequential(input logic [WIDTH-1:0] first, input int count);
    for (int i = 0; i < count; i++) fifo_q.push_back(first + WIDTH'(i));
  endtask

  task automatic checkLog(input string tag, input logic [WIDTH-1:0] first, input int count);
    checkOutput({tag, "_count"}, acc_log.size(), count);
    for (int i = 0; i < count && i < acc_log.size(); i++)
      checkOutput({tag, "_data"}, acc_log[i].data, first + WIDTH'(i));
  endtask

  initial begin
    int idx;
    m_tready   = 1'b0;
    hold_empty = 1'b0;
    exp_fd     = 1'b0;
    pop_index  = 0;
    driveFifo();
    @(negedge clk);
    doReset(2);

    // Full-rate frame: eight beats back to back, one frame_done pulse.
    $display("[TB] full-rate frame");
    loadSequential(8'h10, 8);
    acc_log.delete();
    fd_pulses = 0;
    runUntilIdle(40, 1'b0);
    checkLog("fullrate", 8'h10, 8);
    if (acc_log.size() == 8) begin
      checkOutput("fullrate_tuser0", acc_log[0].sof, 1);
      checkOutput("fullrate_tlast3", acc_log[3].last, 1);
      checkOutput("fullrate_tlast7", acc_log[7].last, 1);
    end
    checkOutput("fullrate_fd_pulses", fd_pulses, 1);

    // Backpressure: only two pops while stalled, head held at 0x10.
    $display("[TB] backpressure");
    doReset(1);
    fifo_q.delete();
    loadSequential(8'h10, 8);
    acc_log.delete();
    rd_pulses = 0;
    applyStimulus(1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0);
    checkOutput("stall_pops", rd_pulses, 2);
    checkOutput("stall_rd", rd, 0);
    checkOutput("stall_head", m_tdata, 8'h10);
    runUntilIdle(40, 1'b0);
    checkLog("stall", 8'h10, 8);

    // Random ready and FIFO bubbles over three frames.
    $display("[TB] random traffic");
    doReset(1);
    for (int i = 0; i < 3 * FRAME; i++) fifo_q.push_back(WIDTH'($urandom));
    acc_log.delete();
    fd_pulses = 0;
    runUntilIdle(600, 1'b1);
    checkOutput("random_beats", acc_log.size(), 3 * FRAME);
    checkOutput("random_fd_pulses", fd_pulses, 3);

    // Reset in the middle of a frame.
    $display("[TB] mid-frame reset");
    doReset(1);
    loadSequential(8'h40, 16);
    acc_log.delete();
    idx = 0;
    while (acc_log.size() < 4 && idx < 20) begin
      applyStimulus(1'b1, 1'b0);
      idx++;
    end
    checkOutput("midreset_pre_beats", acc_log.size(), 4);
    doReset(2);
    idx = acc_log.size();
    runUntilIdle(60, 1'b0);
    if (acc_log.size() > idx) checkOutput("midreset_first_sof", acc_log[idx].sof, 1);
    else checkOutput("midreset_resumed", acc_log.size(), idx + 1);

    // Starved FIFO: nothing moves and position stays at frame start.
    $display("[TB] empty fifo");
    doReset(1);
    fifo_q.delete();
    rd_pulses = 0;
    repeat (20) applyStimulus(1'b1, 1'b0);
    checkOutput("empty_pops", rd_pulses, 0);

    // Single word, then a second word that must sit at x=1.
    $display("[TB] single word");
    acc_log.delete();
    fifo_q.push_back(8'hA5);
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("single_pops", rd_pulses, 1);
    fifo_q.push_back(8'h5A);
    repeat (4) applyStimulus(1'b1, 1'b0);
    checkOutput("single_beats", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      checkOutput("single_first_sof", acc_log[0].sof, 1);
      checkOutput("single_second_sof", acc_log[1].sof, 0);
      checkOutput("single_second_data", acc_log[1].data, 8'h5A);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion to the pixel FIFO. Drains a show-ahead FIFO (`q` valid whenever `empty`=0, `rd` pops) into an AXI-Stream-style master that feeds the 2D FIR core. Tags each beat with start-of-frame and end-of-line. An internal skid register keeps full throughput with no combinational path from `m_tready` to `rd`.

## Interface
- `WIDTH`, 8, pixel/data width; must match the FIFO `WIDTH`.
- `LINE_W`, 640, pixels per line; ≥ 2.
- `LINES`, 480, lines per frame; ≥ 1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `empty`  in  1  FIFO empty flag.
- `q`  in  WIDTH  FIFO head data; valid when `empty`=0.
- `rd`  out  1  FIFO pop strobe; pops the head at this edge.
- `m_tdata`  out  WIDTH  output pixel.
- `m_tvalid`  out  1  output beat valid.
- `m_tready`  in  1  downstream accept.
- `m_tlast`  out  1  last pixel of a line.
- `m_tuser`  out  1  first pixel of a frame (x=0, y=0).
- `frame_done`  out  1  one-cycle pulse when the final beat of a frame is accepted.

## Operation
- Two entries:
  - main register: drives the `m_*` outputs.
  - skid register: `skid_valid` plus data and flags.
  - `skid_valid`=1 implies `m_tvalid`=1.
- `rd = rst_n & ~empty & ~skid_valid`. Purely registered-state based; no dependence on `m_tready`.
- Tagging at pop time:
  - popped word gets `last` = (x == LINE_W-1) and `sof` = (x==0 & y==0).
  - it also gets `eof` = `last` & (y == LINES-1).
- Position counters x (0..LINE_W-1) and y (0..LINES-1) advance only on `rd`.
  - x wraps to 0 after LINE_W-1, and y then increments.
  - y wraps to 0 after LINES-1.
- Handshake: a beat transfers when `m_tvalid & m_tready`. Payload (`m_tdata`, `m_tlast`, `m_tuser`) is held stable while `m_tvalid` & ~`m_tready`.
- Register update per cycle (let `hs` = `m_tvalid & m_tready`):
  - `rd` & (~`m_tvalid` | `hs`): popped word → main.
  - `rd` & `m_tvalid` & ~`m_tready`: popped word → skid, `skid_valid`←1.
  - ~`rd` & `hs` & `skid_valid`: skid → main, `skid_valid`←0.
  - ~`rd` & `hs` & ~`skid_valid`: `m_tvalid`←0.
- `frame_done` = registered (`hs` & main `eof`), asserted in the cycle after the handshake.
- Counter widths: `X_W = max(1,$clog2(LINE_W))`, `Y_W = max(1,$clog2(LINES))`. Compare against LINE_W-1 and LINES-1, never power-of-two wrap.

## Timing
- Reset (async assert, sync deassert by system): `m_tvalid`=0, `skid_valid`=0, x=y=0, `m_tlast`=`m_tuser`=0, `m_tdata`=0, `frame_done`=0, `rd`=0.
- Latency: `rd` at edge N → `m_tvalid`=1 with that word after edge N. One cycle from FIFO non-empty to output valid.
- Throughput: 1 beat/cycle sustained while `empty`=0 and `m_tready`=1.
- Backpressure: at most 2 words are in flight. With `m_tready`=0 and data available, exactly one extra pop into skid occurs, then `rd` stays 0.
- Mid-frame reset: all in-flight words are dropped and counters return to 0. The next popped word carries `m_tuser`=1.
- `empty` toggling: the bubble passes through as `m_tvalid`=0; tagging is unaffected because counters move only on `rd`.

## Structure
- Shared package `fir_pkg`: the `clog2_min1` width helper and the default `LINE_W`/`LINES` frame constants used by the filter top.
- One natural sub-module: `axis_skid_reg` (main + skid entries, WIDTH+3 payload bits). The parent holds the counters, tagging, `rd` and `frame_done`.

## Test plan
- Reset then FIFO preloaded with 0x10..0x17, `LINE_W`=4, `LINES`=2, `m_tready`=1 → 8 consecutive beats 0x10..0x17.
  - `m_tuser` on 0x10 only; `m_tlast` on 0x13 and 0x17.
  - `frame_done` pulses one cycle after 0x17 is accepted.
- Same stream with `m_tready`=0 for 5 cycles after the first valid → exactly 2 pops total, `rd`=0 afterwards, `m_tdata` held at 0x10. Release gives 0x10, 0x11, 0x12… with no loss or duplication.
- Random `m_tready` (50%) and random `empty` over 3 frames → output matches FIFO order; tags are correct at every x=3 and every frame start.
- `rst_n` low during beat 5 of frame 1, `rst_n`=0 held 2 cycles → `m_tvalid`=0 and `rd`=0 immediately. The next accepted word after release has `m_tuser`=1.
- `empty`=1 throughout → `rd`=0, `m_tvalid`=0, and counters stay at 0 indefinitely.
- Single-word FIFO with `m_tready` tied 1 → `rd` one cycle, `m_tvalid` one cycle, x=1 afterwards.
